// File: rtl/regfile_seq_pkg.sv
// Shared types and constants for the register-file instruction sequencer.
package regfile_seq_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 3;

    // Instruction word layout: [15:13] op, [12:10] dst, [9:7] srcA, [6:4] srcB
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 13;
    localparam int DST_MSB  = 12;
    localparam int DST_LSB  = 10;
    localparam int SRCA_MSB = 9;
    localparam int SRCA_LSB = 7;
    localparam int SRCB_MSB = 6;
    localparam int SRCB_LSB = 4;

    typedef enum logic [2:0] {
        OP_NOP = 3'd0,
        OP_LDI = 3'd1,
        OP_ADD = 3'd2,
        OP_SUB = 3'd3,
        OP_AND = 3'd4,
        OP_OR  = 3'd5,
        OP_XOR = 3'd6,
        OP_MOV = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/regfile_seq_alu.sv
// Combinational ALU for the sequencer; results are registered by the caller.
module regfile_seq_alu
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  opcode_e           i_op,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  logic [DATA_W-1:0] i_imm,
    output logic [DATA_W-1:0] o_result,
    output logic              o_carry,
    output logic              o_zero
);

    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;

    // One extra bit catches the carry; for A + ~B + 1 the top bit is the
    // "no borrow" flag, so borrow is its inverse.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} + {1'b0, ~i_b} + {{DATA_W{1'b0}}, 1'b1};

    // Select result and carry by opcode; NOP yields a zero result
    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_LDI: o_result = i_imm;
            OP_ADD: begin
                o_result = w_sum[DATA_W-1:0];
                o_carry  = w_sum[DATA_W];
            end
            OP_SUB: begin
                o_result = w_diff[DATA_W-1:0];
                o_carry  = ~w_diff[DATA_W];
            end
            OP_AND: o_result = i_a & i_b;
            OP_OR:  o_result = i_a | i_b;
            OP_XOR: o_result = i_a ^ i_b;
            OP_MOV: o_result = i_a;
            default: begin
                o_result = '0;
                o_carry  = 1'b0;
            end
        endcase
    end

    assign o_zero = (o_result == '0);

endmodule

// File: rtl/regfile_seq.sv
// Five-state instruction sequencer driving the register-file read and write
// ports: accept, read operands, execute, write back, present result.
module regfile_seq
    import regfile_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [15:0]       in_instr,
    input  logic [DATA_W-1:0] in_imm,
    output logic              write,
    output logic [ADDR_W-1:0] wrAddr,
    output logic [DATA_W-1:0] wrData,
    output logic [ADDR_W-1:0] rdAddrA,
    input  logic [DATA_W-1:0] rdDataA,
    output logic [ADDR_W-1:0] rdAddrB,
    input  logic [DATA_W-1:0] rdDataB,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_carry,
    output logic              out_zero
);

    state_e            r_state;
    state_e            w_next;
    opcode_e           r_op;
    logic [ADDR_W-1:0] r_dst;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_result;
    logic              r_carry;
    logic              r_zero;
    logic              r_write;
    logic [ADDR_W-1:0] r_wrAddr;
    logic [DATA_W-1:0] r_wrData;
    logic [ADDR_W-1:0] r_rdAddrA;
    logic [ADDR_W-1:0] r_rdAddrB;
    logic [DATA_W-1:0] w_result;
    logic              w_carry;
    logic              w_zero;
    logic              w_accept;
    logic              w_unused;

    // Low instruction bits carry no meaning
    assign w_unused = ^in_instr[3:0];
    assign w_accept = (r_state == ST_IDLE) && in_valid;

    regfile_seq_alu #(.DATA_W(DATA_W)) u_alu (
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .i_imm    (r_imm),
        .o_result (w_result),
        .o_carry  (w_carry),
        .o_zero   (w_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next-state: fixed walk through the pipeline, stall only in DONE
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid) w_next = ST_READ;
            ST_READ:  w_next = ST_EXEC;
            ST_EXEC:  w_next = ST_WRITE;
            ST_WRITE: w_next = ST_DONE;
            ST_DONE:  if (out_ready) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
    end

    // Datapath: latch instruction at accept, operands in READ, results in
    // EXEC; the write strobe is armed in EXEC so it is high exactly in WRITE
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op      <= OP_NOP;
            r_dst     <= '0;
            r_imm     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_result  <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
            r_write   <= 1'b0;
            r_wrAddr  <= '0;
            r_wrData  <= '0;
            r_rdAddrA <= '0;
            r_rdAddrB <= '0;
        end else begin
            r_write <= 1'b0;
            if (w_accept) begin
                r_op      <= opcode_e'(in_instr[OP_MSB:OP_LSB]);
                r_dst     <= ADDR_W'(in_instr[DST_MSB:DST_LSB]);
                r_imm     <= in_imm;
                r_rdAddrA <= ADDR_W'(in_instr[SRCA_MSB:SRCA_LSB]);
                r_rdAddrB <= ADDR_W'(in_instr[SRCB_MSB:SRCB_LSB]);
            end
            if (r_state == ST_READ) begin
                r_a <= rdDataA;
                r_b <= rdDataB;
            end
            if (r_state == ST_EXEC) begin
                r_result <= w_result;
                r_carry  <= w_carry;
                r_zero   <= w_zero;
                r_write  <= (r_op != OP_NOP);
                r_wrAddr <= r_dst;
                r_wrData <= w_result;
            end
        end
    end

    assign write     = r_write;
    assign wrAddr    = r_wrAddr;
    assign wrData    = r_wrData;
    assign rdAddrA   = r_rdAddrA;
    assign rdAddrB   = r_rdAddrB;
    assign out_data  = r_result;
    assign out_carry = r_carry;
    assign out_zero  = r_zero;

endmodule

// File: tb/tb_regfile_seq.sv
// Scoreboard bench for regfile_seq with a behavioural register file.
module tb_regfile_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_instr = 16'h0;
    logic [15:0] in_imm = 16'h0;
    logic        write;
    logic [2:0]  wrAddr;
    logic [15:0] wrData;
    logic [2:0]  rdAddrA;
    logic [15:0] rdDataA;
    logic [2:0]  rdAddrB;
    logic [15:0] rdDataB;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        out_carry;
    logic        out_zero;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct { logic [2:0] addr; logic [15:0] data; } wr_t;
    typedef struct { logic [15:0] data; logic carry; logic zero; } out_t;
    wr_t  wr_q[$];
    out_t out_q[$];
    wr_t  mon_e;

    // register file: r0..r3 real, r4..r7 read 0 and drop writes
    logic [15:0] rf[8] = '{default: 16'h0};
    // bench-side expectation of register contents
    logic [15:0] sh[8] = '{default: 16'h0};

    regfile_seq dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_imm(in_imm),
        .write(write), .wrAddr(wrAddr), .wrData(wrData),
        .rdAddrA(rdAddrA), .rdDataA(rdDataA), .rdAddrB(rdAddrB), .rdDataB(rdDataB),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_carry(out_carry), .out_zero(out_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (write && wrAddr < 3'd4) rf[wrAddr] <= wrData;
    assign rdDataA = (rdAddrA < 3'd4) ? rf[rdAddrA] : 16'h0;
    assign rdDataB = (rdAddrB < 3'd4) ? rf[rdAddrB] : 16'h0;

    // write-port scoreboard
    always @(negedge clk) begin
        if (write === 1'b1) begin
            n_tests++;
            if (wr_q.size() == 0) begin
                n_fail++;
                $display("FAIL wr_unexpected: write=1 addr=%0d data=%h, none expected", wrAddr, wrData);
            end else begin
                mon_e = wr_q.pop_front();
                if (wrAddr !== mon_e.addr || wrData !== mon_e.data) begin
                    n_fail++;
                    $display("FAIL wr_port: got addr=%0d data=%h, want addr=%0d data=%h",
                             wrAddr, wrData, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    function automatic logic [15:0] shrd(input logic [2:0] a);
        return (a < 3'd4) ? sh[a] : 16'h0;
    endfunction

    function automatic out_t model(input logic [2:0] op, input logic [15:0] a, b, imm);
        out_t o;
        logic [16:0] s;
        o.data = 16'h0; o.carry = 1'b0;
        case (op)
            3'd1: o.data = imm;
            3'd2: begin s = 17'(a) + 17'(b); o.data = s[15:0]; o.carry = s[16]; end
            3'd3: begin o.data = a - b; o.carry = (a < b); end
            3'd4: o.data = a & b;
            3'd5: o.data = a | b;
            3'd6: o.data = a ^ b;
            3'd7: o.data = a;
            default: o.data = 16'h0;
        endcase
        o.zero = (o.data == 16'h0);
        return o;
    endfunction

    // Drive one instruction through the full handshake, checking cycle timing
    task automatic issue(input logic [2:0] op, dst, sa, sb, input logic [15:0] imm,
                         input int hold, input logic nxt_v, input logic [15:0] nxt_instr,
                         output int waits);
        out_t e, got;
        wr_t  w;
        logic [15:0] held;
        e = model(op, shrd(sa), shrd(sb), imm);
        out_q.push_back(e);
        if (op != 3'd0) begin
            w.addr = dst; w.data = e.data;
            wr_q.push_back(w);
            if (dst < 3'd4) sh[dst] = e.data;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = {op, dst, sa, sb, 4'h0};
        in_imm   = imm;
        waits = 0;
        while (in_ready !== 1'b1 && waits < 20) begin
            @(negedge clk);
            waits++;
        end
        if (waits >= 20) begin
            n_tests++; n_fail++;
            $display("FAIL accept_timeout: in_ready never rose (op=%0d)", op);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            n_tests++;
            if (write !== (c == 3 && op != 3'd0) || out_valid !== (c == 4)) begin
                n_fail++;
                $display("FAIL timing_c%0d: write=%b out_valid=%b, want write=%b out_valid=%b",
                         c, write, out_valid, (c == 3 && op != 3'd0), (c == 4));
            end
            if (c < 4) begin
                n_tests++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_ready_c%0d: in_ready=%b want 0", c, in_ready);
                end
            end
            if (c == 1) begin
                n_tests++;
                if (rdAddrA !== sa || rdAddrB !== sb) begin
                    n_fail++;
                    $display("FAIL rd_addr: got A=%0d B=%0d want A=%0d B=%0d", rdAddrA, rdAddrB, sa, sb);
                end
            end
        end
        got = out_q.pop_front();
        n_tests++;
        if (out_data !== got.data || out_carry !== got.carry || out_zero !== got.zero) begin
            n_fail++;
            $display("FAIL result op=%0d: got data=%h c=%b z=%b want data=%h c=%b z=%b",
                     op, out_data, out_carry, out_zero, got.data, got.carry, got.zero);
        end
        held = out_data;
        if (nxt_v) begin
            in_valid = 1'b1;
            in_instr = nxt_instr;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== held) begin
                n_fail++;
                $display("FAIL stall_h%0d: out_valid=%b in_ready=%b data=%h want 1 0 %h",
                         h, out_valid, in_ready, out_data, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1 || write !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0 ||
            out_carry !== 1'b0 || out_zero !== 1'b0 || rdAddrA !== 3'd0 || wrAddr !== 3'd0 || wrData !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b wr=%b ov=%b d=%h c=%b z=%b ra=%0d wa=%0d wd=%h want 1,0,...",
                     in_ready, write, out_valid, out_data, out_carry, out_zero, rdAddrA, wrAddr, wrData);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready=%b want 1", in_ready);
        end
    endtask

    task automatic test_ldi;
        int w;
        issue(3'd1, 3'd1, 3'd0, 3'd0, 16'h1234, 0, 1'b0, 16'h0, w);
    endtask

    task automatic test_add;
        int w;
        issue(3'd1, 3'd2, 3'd0, 3'd0, 16'hFFFF, 0, 1'b0, 16'h0, w);
        issue(3'd1, 3'd3, 3'd0, 3'd0, 16'h0001, 0, 1'b0, 16'h0, w);
        issue(3'd2, 3'd0, 3'd2, 3'd3, 16'h0000, 0, 1'b0, 16'h0, w);
    endtask

    task automatic test_sub;
        int w;
        issue(3'd1, 3'd2, 3'd0, 3'd0, 16'h0005, 0, 1'b0, 16'h0, w);
        issue(3'd1, 3'd3, 3'd0, 3'd0, 16'h0007, 0, 1'b0, 16'h0, w);
        issue(3'd3, 3'd1, 3'd2, 3'd3, 16'h0000, 0, 1'b0, 16'h0, w);
        issue(3'd3, 3'd1, 3'd3, 3'd2, 16'h0000, 0, 1'b0, 16'h0, w);
    endtask

    task automatic test_back_to_back;
        int w;
        logic [15:0] nxt;
        nxt = {3'd5, 3'd0, 3'd2, 3'd3, 4'h0};
        issue(3'd4, 3'd0, 3'd2, 3'd3, 16'h0000, 3, 1'b1, nxt, w);
        issue(3'd5, 3'd0, 3'd2, 3'd3, 16'h0000, 0, 1'b0, 16'h0, w);
        n_tests++;
        if (w !== 0) begin
            n_fail++;
            $display("FAIL accept_after_release: waited %0d cycles, want 0", w);
        end
        issue(3'd6, 3'd3, 3'd0, 3'd2, 16'h0000, 0, 1'b0, 16'h0, w);
        issue(3'd0, 3'd1, 3'd2, 3'd3, 16'hAAAA, 0, 1'b0, 16'h0, w);
    endtask

    task automatic test_reset_mid;
        int w;
        issue(3'd1, 3'd2, 3'd0, 3'd0, 16'h00AA, 0, 1'b0, 16'h0, w);
        issue(3'd1, 3'd3, 3'd0, 3'd0, 16'h0055, 0, 1'b0, 16'h0, w);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = {3'd2, 3'd1, 3'd2, 3'd3, 4'h0};
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_tests++;
        if (write !== 1'b0 || out_valid !== 1'b0 || out_data !== 16'h0 || out_carry !== 1'b0 ||
            out_zero !== 1'b0 || rdAddrA !== 3'd0 || rdAddrB !== 3'd0 || wrAddr !== 3'd0 || wrData !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_mid: wr=%b ov=%b d=%h c=%b z=%b ra=%0d rb=%0d wa=%0d wd=%h want all 0",
                     write, out_valid, out_data, out_carry, out_zero, rdAddrA, rdAddrB, wrAddr, wrData);
        end
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_ready: in_ready=%b want 1", in_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++;
            if (write !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_write: write=%b want 0", write);
            end
        end
    endtask

    task automatic test_high_addr;
        int w;
        issue(3'd7, 3'd0, 3'd6, 3'd0, 16'h0000, 0, 1'b0, 16'h0, w);
        issue(3'd1, 3'd5, 3'd0, 3'd0, 16'hBEEF, 0, 1'b0, 16'h0, w);
        for (int i = 0; i < 4; i++)
            issue(3'd7, 3'd4, 3'(i), 3'd0, 16'h0000, 0, 1'b0, 16'h0, w);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_ldi();
        test_add();
        test_sub();
        test_back_to_back();
        test_reset_mid();
        test_high_addr();
        repeat (2) @(negedge clk);
        n_tests++;
        if (wr_q.size() != 0) begin
            n_fail++;
            $display("FAIL wr_missing: %0d expected writes never seen, want 0", wr_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_seq.md
# regfile_seq

Instruction sequencer that acts as the initiator on the 16-bit, 3-bit-address register-file port. It accepts one instruction at a time over a valid/ready handshake and drives the two read ports. It evaluates a small ALU operation, issues exactly one write-back, then presents the result downstream with its own valid/ready handshake. It sits between an instruction source and the register file; it is the only master of the register file's write and read-address ports.

## Interface
- DATA_W, 16, datapath width; must match the register file data width
- ADDR_W, 3, register address width; must match the register file address width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  instruction present
- in_ready  out  1  sequencer idle and able to accept
- in_instr  in  16  [15:13] opcode, [12:10] dst, [9:7] srcA, [6:4] srcB, [3:0] ignored
- in_imm  in  DATA_W  immediate, used by LDI only
- write  out  1  register-file write strobe
- wrAddr  out  ADDR_W  write address
- wrData  out  DATA_W  write data
- rdAddrA  out  ADDR_W  read port A address
- rdDataA  in  DATA_W  read port A data, combinational from the register file
- rdAddrB  out  ADDR_W  read port B address
- rdDataB  in  DATA_W  read port B data
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  DATA_W  result written back
- out_carry  out  1  carry (ADD) or borrow (SUB), else 0
- out_zero  out  1  out_data == 0

## Operation
- Opcodes:
  - 0 NOP: no write.
  - 1 LDI: dst <= imm.
  - 2 ADD: dst <= A + B.
  - 3 SUB: dst <= A − B.
  - 4 AND, 5 OR, 6 XOR: dst <= bitwise op of A and B.
  - 7 MOV: dst <= A.
- FSM states:
  - IDLE: in_ready=1; on in_valid go to READ, latching instr and imm.
  - READ: rdAddrA/B are stable; capture rdDataA/B into operand registers; go to EXEC.
  - EXEC: compute result, carry and zero into registers; go to WRITE.
  - WRITE: write=1 for exactly one cycle, except NOP, which has write=0; go to DONE.
  - DONE: out_valid=1; on out_ready go to IDLE.
- rdAddrA/rdAddrB are registered from srcA/srcB at accept. They are held until the next accept.
- wrAddr = dst and wrData = result, registered, valid while write=1.
- Arithmetic:
  - ADD: 17-bit sum; carry = bit 16.
  - SUB: A + ~B + 1; carry = borrow = (A < B unsigned).
  - Results wrap modulo 2^16.
- Addresses 4..7 are forwarded unchanged. The register file returns 0 for reads at those addresses and ignores writes to them. The sequencer does not flag them.
- NOP still traverses all states. It sets out_data=0, out_zero=1, out_carry=0.
- Each out_* signal holds its value until the next EXEC.
- Reset, including mid-operation:
  - Next state is IDLE.
  - write, out_valid, out_data, out_carry, out_zero, rdAddrA, rdAddrB, wrAddr and wrData all clear to 0.
  - A write pending in EXEC is never issued.

## Timing
- Accept edge = cycle 0. READ = cycle 1, EXEC = 2, WRITE = 3 (write high), DONE = 4 onward (out_valid high).
- Minimum issue interval: 5 cycles, achieved when out_ready is high in the first DONE cycle.
- in_ready is high only in IDLE; it is a combinational decode of state. After reset, in_ready=1 in the first cycle.
- No combinational path from rdDataA/B to any output.
- in_valid held high during DONE is ignored. The instruction is accepted in the IDLE cycle that follows.
- Back-to-back instructions read data written by the previous instruction. The write at cycle 3 lands before the next READ at ≥ cycle 6.

## Structure
- Package regfile_seq_pkg contains:
  - opcode enum (NOP…MOV)
  - state enum (IDLE, READ, EXEC, WRITE, DONE)
  - instruction field bit positions
  - DATA_W/ADDR_W defaults
- Sub-module regfile_seq_alu: combinational. Inputs: opcode, A, B, imm. Outputs: result, carry, zero. The sequencer registers these outputs in EXEC.

## Test plan
- Reset, then LDI dst=1, imm=0x1234 → write=1 only in cycle 3 with wrAddr=1, wrData=0x1234. out_valid in cycle 4 with out_data=0x1234, out_zero=0.
- r2=0xFFFF, r3=0x0001, then ADD dst=0, A=2, B=3 → wrData=0x0000, out_carry=1, out_zero=1.
- r2=0x0005, r3=0x0007, then SUB dst=1, A=2, B=3 → wrData=0xFFFE, out_carry=1. SUB 7−5 → 0x0002, out_carry=0.
- Hold out_ready=0 for 3 cycles in DONE while in_valid=1 → in_ready stays 0 and out_data stays stable. Raise out_ready → in_ready=1 on the next cycle; the new instruction is accepted then.
- Assert reset during EXEC of an ADD → write is never asserted and all outputs are 0. in_ready=1 in the cycle after reset deasserts.
- MOV dst=0, A=6 → rdAddrA=6, wrData=0x0000, out_zero=1. LDI dst=5, imm=0xBEEF → write=1 with wrAddr=5, and a subsequent read of r0..r3 is unchanged.
